// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU.
//   One trial subtract per clock; a full divide takes WIDTH+1 edges from the
//   accept edge (WIDTH steps plus one sign-fixup edge).
// Ports:
//   clk, reset      clock; asynchronous active-high reset (forces IDLE)
//   start           request, sampled only in IDLE
//   is_signed       1 = two's complement (DIV), 0 = unsigned (DIVU)
//   opA, opB        dividend, divisor (captured on the accept edge)
//   busy            high from the accept edge until the result edge
//   done            one-cycle pulse with quotient/remainder valid
//   quotient        held until the next done
//   remainder       held until the next done
// Config macro: DIV_EARLY_TERM_EN -- when defined, a divide with |opA| < |opB|
//   (and opB != 0) skips the iteration and completes one edge after accept.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [WIDTH-1:0] dvd;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] div;       // divisor magnitude
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, div_zero;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_neg;
    logic             early_term;

    assign sign_a = is_signed & opA[WIDTH-1];
    assign sign_b = is_signed & opB[WIDTH-1];
    // Negating the most negative value yields itself, which read as unsigned
    // is the correct magnitude.
    assign mag_a  = sign_a ? (~opA + 1'b1) : opA;
    assign mag_b  = sign_b ? (~opB + 1'b1) : opB;

    // rem < div always holds, so a non-negative trial fits in WIDTH bits and
    // a negative one always sets bit WIDTH; WIDTH+1 bits suffice for the sign.
    assign shifted   = {rem, dvd[WIDTH-1]};
    assign trial     = shifted - {1'b0, div};
    assign trial_neg = trial[WIDTH];

`ifdef DIV_EARLY_TERM_EN
    assign early_term = (opB != '0) && (mag_a < mag_b);
`else
    assign early_term = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = early_term ? FIX : ITER;
            ITER:    if (cnt == '0) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            rem       <= '0;
            dvd       <= '0;
            div       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy     <= 1'b1;
                    div      <= mag_b;
                    cnt      <= CW'(WIDTH - 1);
                    q_neg    <= sign_a ^ sign_b;
                    r_neg    <= sign_a;
                    div_zero <= (opB == '0);
                    if (early_term) begin
                        // quotient 0; remainder fixup restores opA
                        rem <= mag_a;
                        dvd <= '0;
                    end else begin
                        rem <= '0;
                        dvd <= mag_a;
                    end
                end
                ITER: begin
                    dvd <= {dvd[WIDTH-2:0], ~trial_neg};
                    rem <= trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    // Divide by zero: the iteration leaves rem = |opA|, so the
                    // normal remainder fixup already returns opA unmodified.
                    quotient  <= div_zero ? '1 : (q_neg ? (~dvd + 1'b1) : dvd);
                    remainder <= r_neg ? (~rem + 1'b1) : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

    localparam int W = 32;
`ifdef DIV_EARLY_TERM_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = W + 1;
`endif
    localparam int LAT_FULL = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] opA, opB;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .opA(opA), .opB(opB), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request, count edges from accept to done, check result.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input int elat);
        int n, bcnt;
        @(negedge clk);
        is_signed = sgn; opA = a; opB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opA = 32'hDEAD_BEEF; opB = 32'h0BAD_F00D; is_signed = ~sgn;
        chk({tag, "_busy_on"}, {31'b0, busy}, 32'd1);
        bcnt = busy ? 1 : 0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!done && busy) bcnt++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_busycnt"}, bcnt, elat);
        chk({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
    endtask

    initial begin
        int ndone, n;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; opA = '0; opB = '0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Back-to-back calls also restart in the done cycle.
        run_div("divu_100_7",  1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_FULL);
        run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_FULL);
        run_div("div_7_m2",    1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, LAT_FULL);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, LAT_FULL);
        run_div("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, LAT_FULL);
        run_div("divu_by0",    1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, LAT_FULL);
        run_div("div_by0",     1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, LAT_FULL);
        run_div("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, LAT_FULL);
        run_div("divu_5_9",    1'b0, 32'd5, 32'd9, 32'd0, 32'd5, LAT_SMALL);
        run_div("div_m5_9",    1'b1, 32'hFFFF_FFFB, 32'd9, 32'd0, 32'hFFFF_FFFB, LAT_SMALL);

        // Start while busy is ignored.
        @(negedge clk);
        is_signed = 1'b0; opA = 32'd1000; opB = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        opA = 32'd77; opB = 32'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0; n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                ndone++;
                chk("ign_q", quotient, 32'd333);
                chk("ign_r", remainder, 32'd1);
            end
        end
        chk("ign_ndone", ndone, 32'd1);

        // Reset in the middle of a divide.
        @(negedge clk);
        is_signed = 1'b0; opA = 32'd50; opB = 32'd6; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_q", quotient, 32'd0);
        chk("mid_rst_r", remainder, 32'd0);
        @(negedge clk); reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 32'd0);
        run_div("after_rst", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, LAT_FULL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
